// File: rtl/bfloat_mult_norm.sv
// bfloat16 multiplier back end: normalize, round, exponent bias and specials over a 2-stage valid/ready pipeline.
// Define BFLOAT_NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module bfloat_mult_norm #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign_a,
  input  logic        in_sign_b,
  input  logic [7:0]  in_exp_a,
  input  logic [7:0]  in_exp_b,
  input  logic [15:0] in_man_prod,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic               r_s1_zero;
  logic               r_s1_inf;
  logic               r_s1_nan;
  logic signed [9:0]  r_s1_esum;
  logic [15:0]        r_s1_prod;

  logic               r_out_valid;
  logic [15:0]        r_out_result;
  logic               r_out_ovf;
  logic               r_out_unf;

  logic               w_s2_adv;
  logic               w_in_ready;
  logic               w_zero;
  logic               w_inf;
  logic signed [9:0]  w_esum;

  logic [6:0]         w_m;
  logic [6:0]         w_m_r;
  logic               w_carry;
  logic               w_rup;
  logic signed [9:0]  w_e;
  logic signed [9:0]  w_e_r;
  logic [15:0]        w_result;
  logic               w_ovf;
  logic               w_unf;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  assign w_zero = (in_exp_a == 8'd0) || (in_exp_b == 8'd0);
  assign w_inf  = (in_exp_a == 8'hFF) || (in_exp_b == 8'hFF);
  // Zero-extended sum fits 10-bit signed range (-127..383) without wrap.
  assign w_esum = signed'({2'b00, in_exp_a} + {2'b00, in_exp_b} - 10'(EXP_BIAS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_esum  <= '0;
      r_s1_prod  <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign_a ^ in_sign_b;
        r_s1_zero <= w_zero;
        r_s1_inf  <= w_inf;
        r_s1_nan  <= in_nan || (w_inf && w_zero);
        r_s1_esum <= w_esum;
        r_s1_prod <= in_man_prod;
      end
    end
  end

`ifdef BFLOAT_NORM_RNE_EN
  logic w_g;
  logic w_s;
  always_comb begin
    w_g   = r_s1_prod[15] ? r_s1_prod[7] : r_s1_prod[6];
    w_s   = r_s1_prod[15] ? (|r_s1_prod[6:0]) : (|r_s1_prod[5:0]);
    w_rup = w_g && (w_s || w_m[0]);
  end
`else
  logic w_unused_lo;
  assign w_unused_lo = ^r_s1_prod[6:0];
  assign w_rup       = 1'b0;
`endif

  always_comb begin
    w_m      = r_s1_prod[15] ? r_s1_prod[14:8] : r_s1_prod[13:7];
    w_e      = r_s1_prod[15] ? (r_s1_esum + 10'sd1) : r_s1_esum;
    // Mantissa carry-out on 7F+1 wraps m_r to 0 and bumps the exponent.
    {w_carry, w_m_r} = {1'b0, w_m} + {7'd0, w_rup};
    w_e_r    = w_e + signed'({9'd0, w_carry});
    w_result = {r_s1_sign, w_e_r[7:0], w_m_r};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_s1_nan) begin
      w_result = 16'h7FC0;
    end else if (r_s1_inf) begin
      w_result = {r_s1_sign, 8'hFF, 7'h00};
    end else if (r_s1_zero) begin
      w_result = {r_s1_sign, 15'h0000};
    end else if (w_e_r >= 10'sd255) begin
      w_result = {r_s1_sign, 8'hFF, 7'h00};
      w_ovf    = 1'b1;
    end else if (w_e_r <= 10'sd0) begin
      w_result = {r_s1_sign, 15'h0000};
      w_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
      r_out_unf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_result;
        r_out_ovf    <= w_ovf;
        r_out_unf    <= w_unf;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovf    = r_out_ovf;
  assign out_unf    = r_out_unf;

endmodule
